// File: rtl/kernel_run_ctrl.sv
// Run sequencer: drives ap_ctrl_hs for NUM_RUNS kernel executions, folds output-stream
// writes into a 32-bit signature per run and shifts it out as 8 nibbles on the board pins.
module kernel_run_ctrl #(
  parameter int NUM_RUNS   = 2,
  parameter int CNT_W      = 6,
  parameter int DATA_W     = 32,
  parameter int GAP_CYCLES = 16
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              enable,
  output logic              k_ap_start,
  input  logic              k_ap_ready,
  input  logic              k_ap_done,
  input  logic              d_out_write,
  input  logic [DATA_W-1:0] d_out_din,
  output logic              probe_out,
  output logic [3:0]        data_out,
  output logic              data_valid,
  output logic [CNT_W-1:0]  run_cnt,
  output logic              busy,
  output logic              all_done
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, START, WAIT_DONE, REPORT, GAP, FINISH} state_t;

  typedef struct packed {
    logic       vld;
    logic [3:0] nib;
  } rpt_t;

  state_t            state;
  rpt_t              rpt;
  logic [DATA_W-1:0] sig, sig_nx, shreg;
  logic [2:0]        rpt_cnt;
  logic [GW-1:0]     gap_cnt;
  logic              run_st, done_acc;

  assign data_out   = rpt.nib;
  assign data_valid = rpt.vld;

  assign run_st   = (state == START) || (state == WAIT_DONE);
  // done only counts once the kernel has taken the start (ready seen this cycle or earlier)
  assign done_acc = k_ap_done && (((state == START) && k_ap_ready) || (state == WAIT_DONE));

  always_comb begin
    sig_nx = sig;
    if (run_st && d_out_write)
      sig_nx = {sig[DATA_W-2:0], sig[DATA_W-1]} ^ d_out_din;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state      <= IDLE;
      k_ap_start <= 1'b0;
      probe_out  <= 1'b0;
      rpt        <= '0;
      run_cnt    <= '0;
      busy       <= 1'b0;
      all_done   <= 1'b0;
      sig        <= '0;
      shreg      <= '0;
      rpt_cnt    <= '0;
      gap_cnt    <= '0;
    end else begin
      sig <= sig_nx;
      case (state)
        IDLE: if (enable) begin
          state      <= START;
          k_ap_start <= 1'b1;
          busy       <= 1'b1;
          run_cnt    <= '0;
          sig        <= '0;
        end
        START, WAIT_DONE: begin
          if (done_acc) begin
            state      <= REPORT;
            k_ap_start <= 1'b0;
            probe_out  <= ~probe_out;
            if (run_cnt != '1) run_cnt <= run_cnt + CNT_W'(1);
            rpt        <= '{vld: 1'b1, nib: sig_nx[DATA_W-1 -: 4]};
            shreg      <= {sig_nx[DATA_W-5:0], 4'h0};
            rpt_cnt    <= '0;
          end else if ((state == START) && k_ap_ready) begin
            state      <= WAIT_DONE;
            k_ap_start <= 1'b0;
          end
        end
        REPORT: begin
          rpt_cnt <= rpt_cnt + 3'd1;
          if (rpt_cnt == 3'd7) begin
            state   <= GAP;
            rpt     <= '0;
            gap_cnt <= '0;
          end else begin
            rpt   <= '{vld: 1'b1, nib: shreg[DATA_W-1 -: 4]};
            shreg <= {shreg[DATA_W-5:0], 4'h0};
          end
        end
        GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            if (run_cnt == CNT_W'(NUM_RUNS)) begin
              state    <= FINISH;
              busy     <= 1'b0;
              all_done <= 1'b1;
            end else if (enable) begin
              state      <= START;
              k_ap_start <= 1'b1;
              sig        <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        FINISH: if (!enable) begin
          state    <= IDLE;
          all_done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_run_ctrl.sv
// Bench for kernel_run_ctrl: kernel handshake model, signature scoreboard on the nibble port.
module tb_kernel_run_ctrl;

  localparam int NUM_RUNS   = 2;
  localparam int CNT_W      = 6;
  localparam int DATA_W     = 32;
  localparam int GAP_CYCLES = 16;

  logic              ap_clk = 1'b0;
  logic              ap_rst_n = 1'b0;
  logic              enable = 1'b0;
  logic              k_ap_start;
  logic              k_ap_ready = 1'b0;
  logic              k_ap_done = 1'b0;
  logic              d_out_write = 1'b0;
  logic [DATA_W-1:0] d_out_din = '0;
  logic              probe_out;
  logic [3:0]        data_out;
  logic              data_valid;
  logic [CNT_W-1:0]  run_cnt;
  logic              busy;
  logic              all_done;

  int         n_chk = 0;
  int         n_fail = 0;
  logic [3:0] exp_q[$];
  logic       exp_probe = 1'b0;
  int         exp_cnt = 0;
  bit         mon_en = 1'b0;
  int         dv_cnt = 0;

  kernel_run_ctrl #(.NUM_RUNS(NUM_RUNS), .CNT_W(CNT_W), .DATA_W(DATA_W), .GAP_CYCLES(GAP_CYCLES)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .enable(enable),
    .k_ap_start(k_ap_start), .k_ap_ready(k_ap_ready), .k_ap_done(k_ap_done),
    .d_out_write(d_out_write), .d_out_din(d_out_din),
    .probe_out(probe_out), .data_out(data_out), .data_valid(data_valid),
    .run_cnt(run_cnt), .busy(busy), .all_done(all_done)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rot(input logic [31:0] v);
    return {v[30:0], v[31]};
  endfunction

  task automatic push_sig(input logic [31:0] s);
    for (int i = 7; i >= 0; i--) exp_q.push_back(s[i*4 +: 4]);
  endtask

  // Kernel model: ready after rdy_lat cycles of start; done_lat==0 means ready+done together.
  task automatic kernel_exec(input int rdy_lat, input int done_lat, input int nw,
                             input logic [31:0] w0, input logic [31:0] w1, input bit drop_en);
    logic [31:0] s;
    int t;
    s = '0;
    t = 0;
    while (!k_ap_start && t < 300) begin @(negedge ap_clk); t++; end
    chk("start_seen", k_ap_start, 1);
    repeat (rdy_lat) @(negedge ap_clk);
    chk("start_held", k_ap_start, 1);
    k_ap_ready = 1'b1;
    if (done_lat == 0) begin
      if (nw > 0) begin d_out_write = 1'b1; d_out_din = w0; s = rot(s) ^ w0; end
      k_ap_done = 1'b1;
      push_sig(s);
    end
    @(negedge ap_clk);
    k_ap_ready = 1'b0;
    d_out_write = 1'b0;
    if (done_lat != 0) begin
      chk("start_drop", k_ap_start, 0);
      if (drop_en) enable = 1'b0;
      for (int i = 0; i < nw; i++) begin
        d_out_write = 1'b1;
        d_out_din = (i == 0) ? w0 : w1;
        s = rot(s) ^ d_out_din;
        @(negedge ap_clk);
      end
      d_out_write = 1'b0;
      repeat (done_lat) @(negedge ap_clk);
      k_ap_done = 1'b1;
      push_sig(s);
      @(negedge ap_clk);
    end
    k_ap_done = 1'b0;
    exp_probe = ~exp_probe;
    exp_cnt++;
    chk("probe_tog", probe_out, exp_probe);
    chk("run_cnt", run_cnt, exp_cnt);
    chk("dv_rise", data_valid, 1);
  endtask

  task automatic wait_all_done();
    int t;
    t = 0;
    while (!all_done && t < 200) begin @(negedge ap_clk); t++; end
    chk("all_done", all_done, 1);
  endtask

  always @(negedge ap_clk) begin
    if (mon_en) begin
      if (data_valid) begin
        dv_cnt++;
        if (exp_q.size() == 0) chk("dv_extra", 1, 0);
        else chk("nibble", data_out, exp_q.pop_front());
      end else begin
        chk("dout_quiet", data_out, 0);
        if (dv_cnt != 0) begin
          chk("dv_len", dv_cnt, 8);
          dv_cnt = 0;
        end
      end
    end else begin
      dv_cnt = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge ap_clk);
    chk("rst_start", k_ap_start, 0);
    chk("rst_probe", probe_out, 0);
    chk("rst_dv", data_valid, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_cnt", run_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", all_done, 0);
    ap_rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge ap_clk);
    chk("idle_start", k_ap_start, 0);

    // Session 1: writes 1,2 (sig 0) then 0xDEADBEEF; stray done in GAP and FINISH
    enable = 1'b1;
    exp_cnt = 0;
    @(negedge ap_clk);
    chk("start_lat", k_ap_start, 1);
    chk("busy_on", busy, 1);
    kernel_exec(3, 50, 2, 32'h1, 32'h2, 1'b0);
    n = 0;
    while (!k_ap_start && n < 100) begin
      k_ap_done = (n == 11);
      @(negedge ap_clk);
      n++;
    end
    k_ap_done = 1'b0;
    chk("gap_len", n, 8 + GAP_CYCLES);
    chk("gap_stray_cnt", run_cnt, exp_cnt);
    chk("gap_stray_probe", probe_out, exp_probe);
    kernel_exec(3, 50, 1, 32'hDEADBEEF, 32'h0, 1'b0);
    wait_all_done();
    chk("s1_cnt", run_cnt, 2);
    chk("s1_probe", probe_out, 0);
    chk("s1_busy", busy, 0);
    k_ap_done = 1'b1;
    @(negedge ap_clk);
    k_ap_done = 1'b0;
    repeat (2) @(negedge ap_clk);
    chk("fin_stray_probe", probe_out, exp_probe);
    chk("fin_stray_cnt", run_cnt, 2);
    chk("fin_hold", all_done, 1);
    enable = 1'b0;
    repeat (2) @(negedge ap_clk);
    chk("fin_exit", all_done, 0);

    // Session 2: ready and done in the same cycle, write 0x12345678 in that cycle
    enable = 1'b1;
    exp_cnt = 0;
    kernel_exec(2, 0, 1, 32'h12345678, 32'h0, 1'b0);
    kernel_exec(1, 5, 0, 32'h0, 32'h0, 1'b0);
    wait_all_done();
    enable = 1'b0;
    repeat (2) @(negedge ap_clk);
    chk("s2_exit", all_done, 0);

    // Session 3: reset during REPORT
    enable = 1'b1;
    exp_cnt = 0;
    kernel_exec(2, 10, 1, 32'hCAFEF00D, 32'h0, 1'b0);
    repeat (3) @(negedge ap_clk);
    mon_en = 1'b0;
    ap_rst_n = 1'b0;
    enable = 1'b0;
    #1;
    chk("arst_dv", data_valid, 0);
    chk("arst_dout", data_out, 0);
    chk("arst_probe", probe_out, 0);
    chk("arst_cnt", run_cnt, 0);
    chk("arst_busy", busy, 0);
    chk("arst_start", k_ap_start, 0);
    exp_q.delete();
    exp_probe = 1'b0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    mon_en = 1'b1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge ap_clk);
      if (data_valid || k_ap_start) n++;
    end
    chk("arst_quiet", n, 0);

    // Session 4: enable dropped during WAIT_DONE
    enable = 1'b1;
    exp_cnt = 0;
    kernel_exec(2, 20, 1, 32'hA5A5_0F0F, 32'h0, 1'b0 | 1'b1);
    repeat (8 + GAP_CYCLES + 3) @(negedge ap_clk);
    chk("drop_busy", busy, 0);
    chk("drop_done", all_done, 0);
    chk("drop_cnt", run_cnt, 1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge ap_clk);
      if (k_ap_start) n++;
    end
    chk("drop_nostart", n, 0);

    chk("q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/kernel_run_ctrl.md
# kernel_run_ctrl

Run sequencer for the HLS kernel under power characterisation. It drives the kernel's ap_ctrl_hs start/ready/done handshake for NUM_RUNS back-to-back executions and folds every output-stream write into a per-run 32-bit signature. After each run it serialises the signature onto the 4-bit `data_out`/`data_valid` board pins and toggles `probe_out` as a run marker. It sits in the board wrapper between the kernel instance and the I/O pins.

## Interface
- NUM_RUNS, 2, executions per enable session (1..2^CNT_W-1)
- CNT_W, 6, width of run counter
- DATA_W, 32, width of kernel output stream (fixed at 32; signature is 32 b)
- GAP_CYCLES, 16, idle cycles between end of report and next start (≥1)
- ap_clk  in  1  kernel clock; all logic on rising edge
- ap_rst_n  in  1  asynchronous active-low reset
- enable  in  1  level; request a run session
- k_ap_start  out  1  kernel ap_start
- k_ap_ready  in  1  kernel ap_ready
- k_ap_done  in  1  kernel ap_done (1-cycle pulse)
- d_out_write  in  1  kernel output stream write strobe
- d_out_din  in  DATA_W  kernel output stream data
- probe_out  out  1  toggles once per kernel ap_done
- data_out  out  4  signature nibble
- data_valid  out  1  qualifies data_out
- run_cnt  out  CNT_W  completed runs this session
- busy  out  1  high in any state except IDLE/FINISH
- all_done  out  1  high in FINISH

## Operation
- States: IDLE, START, WAIT_DONE, REPORT, GAP, FINISH.
- IDLE: outputs quiet; on enable=1 → START, clear run_cnt, clear signature.
- START: k_ap_start=1; held until k_ap_ready sampled 1, then → WAIT_DONE (k_ap_start=0 next cycle). If k_ap_done=1 in the same cycle as k_ap_ready, go directly to REPORT (done handled as below).
- WAIT_DONE: k_ap_start=0; on k_ap_done=1 → REPORT.
- On every accepted k_ap_done: probe_out toggles, run_cnt increments (saturating at all-ones), signature latched into shift register.
- Signature: in START/WAIT_DONE, each cycle with d_out_write=1: sig ← {sig[30:0],sig[31]} ^ d_out_din. A write in the same cycle as k_ap_done is included in the latched value. Writes in other states ignored. sig cleared to 0 on entering START.
- REPORT: exactly 8 cycles, data_valid=1, data_out = signature nibbles MS first (bits 31:28 first, 3:0 last). Then → GAP.
- GAP: GAP_CYCLES cycles, k_ap_start=0. At end: if run_cnt==NUM_RUNS → FINISH; else if enable=1 → START; else → IDLE.
- FINISH: all_done=1; hold until enable=0, then → IDLE.
- enable deasserted during START/WAIT_DONE/REPORT has no effect; the run completes and reports.
- Stray k_ap_done in IDLE/GAP/REPORT/FINISH ignored (no toggle, no count).

## Timing
- Reset (async assert, sync to state): state=IDLE, k_ap_start=0, probe_out=0, data_out=0, data_valid=0, run_cnt=0, busy=0, all_done=0, sig=0.
- All outputs registered.
- enable high at edge N (in IDLE) → k_ap_start=1 from edge N+1.
- k_ap_done at edge M → probe_out/run_cnt update at M+1; data_valid=1 for edges M+1..M+8; next k_ap_start=1 at M+9+GAP_CYCLES (if runs remain).
- data_out=0 whenever data_valid=0.

## Test plan
- Single session, NUM_RUNS=2, kernel model ready after 3 cycles, done after 50, writes 0x00000001 then 0x00000002 → per run data_out sequence 0,0,0,0,0,0,0,0 then 0,... with sig 0x00000000^... computed: 1→sig=1; then {2}^2=0 → nibbles all 0; probe_out toggles twice, run_cnt=2, all_done=1.
- Writes 0xDEADBEEF only → 8 nibbles D,E,A,D,B,E,E,F with data_valid high exactly 8 cycles.
- k_ap_ready and k_ap_done in same cycle with write 0x12345678 in that cycle → REPORT entered directly, nibbles 1..8, run_cnt+1.
- enable dropped mid WAIT_DONE with NUM_RUNS=2 → run 1 completes and reports, then IDLE after GAP, run_cnt=1, all_done=0, no second start.
- ap_rst_n pulsed low during REPORT → all outputs at reset values immediately, probe_out=0, no further data_valid.
- Stray k_ap_done in GAP and FINISH → probe_out and run_cnt unchanged.
